// File: rtl/rx_gather_fifo_pkg.sv
// rx_gather_fifo_pkg: sizing constants and shared types for the RX gather FIFO
package rx_gather_fifo_pkg;
    localparam int FifoEntryWidth     = 8;
    localparam int FifoEntryWidthSize = 3;
    localparam int FifoAddrWidth      = 6;
    localparam int FifoBlockAddrWidth = FifoAddrWidth - FifoEntryWidthSize;
    localparam int FifoBlockSize      = 1 << FifoBlockAddrWidth;
    typedef logic [FifoEntryWidthSize:0] pop_width_t;
    typedef logic [FifoAddrWidth-1:0]    fifo_ptr_t;
endpackage

// File: rtl/rx_gather_fifo_sdpram_block.sv
// rx_gather_fifo_sdpram_block: one byte bank, single write port, synchronous read held until the next read
module rx_gather_fifo_sdpram_block
    import rx_gather_fifo_pkg::*;
#(
    parameter int DataWidth = 8,
    parameter int AddrWidth = FifoBlockAddrWidth
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [AddrWidth-1:0] waddr,
    input  logic [DataWidth-1:0] wdata,
    input  logic                 re,
    input  logic [AddrWidth-1:0] raddr,
    output logic [DataWidth-1:0] rdata
);
    logic [DataWidth-1:0] mem_q [1 << AddrWidth];
    logic [DataWidth-1:0] rdata_q, rdata_d;
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end
    always_comb rdata_d = re ? mem_q[raddr] : rdata_q;
    // only the read register is reset; the array keeps its contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else rdata_q <= rdata_d;
    end
    assign rdata = rdata_q;
endmodule

// File: rtl/rx_gather_fifo.sv
// rx_gather_fifo: byte-push / multi-byte-pop RX FIFO over interleaved byte banks, one read cycle per pop
module rx_gather_fifo #(
    parameter int FifoEntryWidth     = rx_gather_fifo_pkg::FifoEntryWidth,
    parameter int FifoEntryWidthSize = rx_gather_fifo_pkg::FifoEntryWidthSize,
    parameter int FifoAddrWidth      = rx_gather_fifo_pkg::FifoAddrWidth,
    parameter int FifoBlockAddrWidth = rx_gather_fifo_pkg::FifoBlockAddrWidth
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push_valid,
    input  logic [7:0]                    push_data,
    output logic                          push_ready,
    input  logic                          pop_req,
    input  logic [FifoEntryWidthSize:0]   pop_width,
    output logic                          rdata_valid,
    output logic [FifoEntryWidth*8-1:0]   rdata,
    output logic                          pop_err,
    output logic [FifoAddrWidth:0]        level,
    output logic                          empty,
    output logic                          full,
    output logic                          overrun,
    input  logic                          clear_overrun
);
    import rx_gather_fifo_pkg::*;
    localparam int Depth = 1 << FifoAddrWidth;
    localparam int Ws = FifoEntryWidthSize;
    logic [FifoAddrWidth-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FifoAddrWidth:0]   level_q, level_d, pop_bytes;
    logic [Ws-1:0]            off_q, off_d;
    logic [Ws:0]              width_q, width_d;
    logic                     rdata_valid_q, rdata_valid_d;
    logic                     pop_err_q, pop_err_d;
    logic                     overrun_q, overrun_d;
    logic                     push_acc, pop_acc, width_ok;
    logic [7:0]               bank_rdata [FifoEntryWidth];
    assign full        = level_q == (FifoAddrWidth+1)'(Depth);
    assign empty       = level_q == '0;
    assign push_ready  = !full;
    assign level       = level_q;
    assign rdata_valid = rdata_valid_q;
    assign pop_err     = pop_err_q;
    assign overrun     = overrun_q;
    always_comb begin
        push_acc      = push_valid && push_ready;
        width_ok      = pop_width != '0 && pop_width <= (Ws+1)'(FifoEntryWidth);
        pop_bytes     = (FifoAddrWidth+1)'(pop_width);
        pop_acc       = pop_req && width_ok && pop_bytes <= level_q;
        wr_ptr_d      = wr_ptr_q + FifoAddrWidth'(push_acc);
        rd_ptr_d      = rd_ptr_q + (pop_acc ? FifoAddrWidth'(pop_width) : '0);
        level_d       = level_q + (FifoAddrWidth+1)'(push_acc) - (pop_acc ? pop_bytes : '0);
        off_d         = pop_acc ? rd_ptr_q[Ws-1:0] : off_q;
        width_d       = pop_acc ? pop_width : width_q;
        rdata_valid_d = pop_acc;
        pop_err_d     = pop_req && !pop_acc;
        overrun_d     = (push_valid && !push_ready) || (overrun_q && !clear_overrun);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            off_q         <= '0;
            width_q       <= '0;
            rdata_valid_q <= 1'b0;
            pop_err_q     <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            off_q         <= off_d;
            width_q       <= width_d;
            rdata_valid_q <= rdata_valid_d;
            pop_err_q     <= pop_err_d;
            overrun_q     <= overrun_d;
        end
    end
    // banks below the lane offset belong to the next row of this pop
    for (genvar k = 0; k < FifoEntryWidth; k++) begin : g_bank
        logic [FifoBlockAddrWidth-1:0] raddr;
        assign raddr = rd_ptr_q[FifoAddrWidth-1:Ws]
                     + FifoBlockAddrWidth'(Ws'(k) < rd_ptr_q[Ws-1:0]);
        rx_gather_fifo_sdpram_block #(
            .DataWidth(8),
            .AddrWidth(FifoBlockAddrWidth)
        ) u_bank (
            .clk   (clk),
            .rst_n (reset),
            .we    (push_acc && wr_ptr_q[Ws-1:0] == Ws'(k)),
            .waddr (wr_ptr_q[FifoAddrWidth-1:Ws]),
            .wdata (push_data),
            .re    (pop_acc),
            .raddr (raddr),
            .rdata (bank_rdata[k])
        );
    end
    // output byte j (from the LSB) is pop byte w-1-j, held in bank (off + w-1-j) mod W
    for (genvar j = 0; j < FifoEntryWidth; j++) begin : g_lane
        logic [Ws-1:0] src;
        assign src = off_q + width_q[Ws-1:0] - Ws'(j + 1);
        assign rdata[j*8 +: 8] = ((Ws+1)'(j) < width_q) ? bank_rdata[src] : 8'h00;
    end
endmodule

// File: tb/tb_rx_gather_fifo.sv
// tb_rx_gather_fifo: vector table, corner sequences and random traffic checked against a byte-queue model
module tb_rx_gather_fifo;
    import rx_gather_fifo_pkg::*;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        push_valid = 1'b0;
    logic [7:0]  push_data = 8'h00;
    logic        push_ready;
    logic        pop_req = 1'b0;
    pop_width_t  pop_width = '0;
    logic        rdata_valid;
    logic [63:0] rdata;
    logic        pop_err;
    logic [6:0]  level;
    logic        empty, full, overrun;
    logic        clear_overrun = 1'b0;

    always #5 clk = ~clk;

    rx_gather_fifo dut (
        .clk(clk), .reset(reset), .push_valid(push_valid), .push_data(push_data),
        .push_ready(push_ready), .pop_req(pop_req), .pop_width(pop_width),
        .rdata_valid(rdata_valid), .rdata(rdata), .pop_err(pop_err), .level(level),
        .empty(empty), .full(full), .overrun(overrun), .clear_overrun(clear_overrun)
    );

    int n_checks = 0;
    int n_fail = 0;
    byte unsigned q[$];
    logic [63:0] m_rdata = '0;
    logic m_valid = 1'b0, m_err = 1'b0, m_ovr = 1'b0;

    typedef struct {
        logic       pv;
        logic [7:0] pd;
        logic       pr;
        logic [3:0] pw;
        logic [6:0] lvl;
        logic       vld;
        logic       err;
        logic [63:0] rd;
    } vec_t;
    vec_t tbl[25];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        check("rdata_valid", 64'(rdata_valid), 64'(m_valid));
        check("pop_err", 64'(pop_err), 64'(m_err));
        check("level", 64'(level), 64'(q.size()));
        check("empty", 64'(empty), 64'(q.size() == 0));
        check("full", 64'(full), 64'(q.size() == 64));
        check("push_ready", 64'(push_ready), 64'(q.size() < 64));
        check("overrun", 64'(overrun), 64'(m_ovr));
        check("rdata", rdata, m_rdata);
    endtask

    task automatic cycle(input logic pv, input logic [7:0] pd, input logic pr,
                         input logic [3:0] pw, input logic co);
        int lvl;
        bit pop_ok, push_ok;
        lvl = q.size();
        pop_ok = pr && pw >= 1 && pw <= 8 && int'(pw) <= lvl;
        push_ok = pv && lvl < 64;
        push_valid = pv;
        push_data = pd;
        pop_req = pr;
        pop_width = pw;
        clear_overrun = co;
        if (pop_ok) begin
            m_rdata = '0;
            for (int i = 0; i < int'(pw); i++) m_rdata = (m_rdata << 8) | 64'(q.pop_front());
        end
        if (push_ok) q.push_back(pd);
        m_valid = pop_ok;
        m_err = pr && !pop_ok;
        m_ovr = (pv && lvl >= 64) ? 1'b1 : (co ? 1'b0 : m_ovr);
        @(posedge clk);
        #1;
        push_valid = 1'b0;
        pop_req = 1'b0;
        clear_overrun = 1'b0;
        check_all();
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        q.delete();
        m_rdata = '0;
        m_valid = 1'b0;
        m_err = 1'b0;
        m_ovr = 1'b0;
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b1, 8'(8'h11 + i), 1'b0, 4'd0, 7'(i + 1), 1'b0, 1'b0, 64'h0};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 4'd8, 7'd0, 1'b1, 1'b0, 64'h1112131415161718};
        for (int i = 0; i < 3; i++)
            tbl[9 + i] = '{1'b1, 8'(8'hA0 + i), 1'b0, 4'd0, 7'(i + 1), 1'b0, 1'b0, 64'h1112131415161718};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 4'd4, 7'd3, 1'b0, 1'b1, 64'h1112131415161718};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 4'd0, 7'd3, 1'b0, 1'b1, 64'h1112131415161718};
        tbl[14] = '{1'b0, 8'h00, 1'b1, 4'd9, 7'd3, 1'b0, 1'b1, 64'h1112131415161718};
        tbl[15] = '{1'b0, 8'h00, 1'b1, 4'd2, 7'd1, 1'b1, 1'b0, 64'h000000000000A0A1};
        for (int i = 0; i < 8; i++)
            tbl[16 + i] = '{1'b1, 8'(8'hB0 + i), 1'b0, 4'd0, 7'(i + 2), 1'b0, 1'b0, 64'h000000000000A0A1};
        tbl[24] = '{1'b0, 8'h00, 1'b1, 4'd8, 7'd1, 1'b1, 1'b0, 64'hA2B0B1B2B3B4B5B6};

        @(posedge clk);
        #1;
        check_all();
        reset = 1'b1;

        for (int i = 0; i < 25; i++) begin
            cycle(tbl[i].pv, tbl[i].pd, tbl[i].pr, tbl[i].pw, 1'b0);
            check($sformatf("vec%0d level", i), 64'(level), 64'(tbl[i].lvl));
            check($sformatf("vec%0d valid", i), 64'(rdata_valid), 64'(tbl[i].vld));
            check($sformatf("vec%0d err", i), 64'(pop_err), 64'(tbl[i].err));
            check($sformatf("vec%0d rdata", i), rdata, tbl[i].rd);
        end

        do_reset();
        for (int i = 0; i < 64; i++) cycle(1'b1, 8'($urandom), 1'b0, 4'd0, 1'b0);
        check("fill full", 64'(full), 64'd1);
        check("fill push_ready", 64'(push_ready), 64'd0);
        cycle(1'b1, 8'h55, 1'b0, 4'd0, 1'b0);
        check("overrun set", 64'(overrun), 64'd1);
        check("overrun level", 64'(level), 64'd64);
        cycle(1'b1, 8'h66, 1'b1, 4'd1, 1'b0);
        check("pop at full level", 64'(level), 64'd63);
        cycle(1'b1, 8'h77, 1'b0, 4'd0, 1'b0);
        check("refill level", 64'(level), 64'd64);
        cycle(1'b0, 8'h00, 1'b0, 4'd0, 1'b1);
        check("overrun cleared", 64'(overrun), 64'd0);

        do_reset();
        for (int i = 0; i < 60; i++) cycle(1'b1, 8'(i), 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b1, 4'd8, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 4'd4, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 4'd0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 4'd8, 1'b0);
        check("wrap rdata", rdata, 64'hC0C1C2C3C4C5C6C7);
        check("wrap empty", 64'(empty), 64'd1);

        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hD0 + i), 1'b0, 4'd0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 4'd5, 1'b0);
        check("pre-reset valid", 64'(rdata_valid), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("async reset valid", 64'(rdata_valid), 64'd0);
        check("async reset level", 64'(level), 64'd0);
        check("async reset rdata", rdata, 64'd0);
        #1 reset = 1'b1;
        q.delete();
        m_rdata = '0;
        m_valid = 1'b0;
        m_err = 1'b0;
        m_ovr = 1'b0;
        cycle(1'b0, 8'h00, 1'b1, 4'd1, 1'b0);
        check("post-reset pop_err", 64'(pop_err), 64'd1);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int push_pct;
            push_pct = (i % 1000 < 500) ? 85 : 40;
            cycle(1'($urandom_range(0, 99) < push_pct), 8'($urandom),
                  1'($urandom_range(0, 99) < 35), 4'($urandom_range(0, 9)),
                  1'($urandom_range(0, 19) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
